// File: rtl/ahb_apb_bus_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : ahb_arb_pkg                                                      |
// | Shared state encoding and width helpers for the AHB-to-APB arbiter.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package ahb_arb_pkg;

  typedef enum logic [1:0] {
    ST_PARK   = 2'd0,
    ST_OWN    = 2'd1,
    ST_LOCKED = 2'd2
  } arb_state_t;

  localparam int C_MIN_MASTERS = 2;
  localparam int C_MAX_MASTERS = 8;
  localparam int C_MIN_BEATS   = 1;
  localparam int C_MAX_BEATS   = 255;

  function automatic int mw_f(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int bw_f(input int b);
    return $clog2(b + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ahb_apb_bus_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface : ahb_apb_bus_arbiter_if                                         |
// | Request/grant bundle between the AHB requesters and the bus arbiter.       |
// | Revision  : 1.0                                                            |
// +----------------------------------------------------------------------------+
interface ahb_apb_bus_arbiter_if #(
  parameter int NUM_MASTERS = 4,
  parameter int MAX_BEATS   = 8
) ();
  import ahb_arb_pkg::*;

  localparam int MW = mw_f(NUM_MASTERS);
  localparam int BW = bw_f(MAX_BEATS);

  logic [NUM_MASTERS-1:0] HBUSREQ;
  logic [NUM_MASTERS-1:0] HLOCK;
  logic                   HREADY;
  logic                   Valid;
  logic [NUM_MASTERS-1:0] HGRANT;
  logic [MW-1:0]          HMASTER;
  logic                   HMASTLOCK;
  logic [BW-1:0]          beat_cnt;

  // Requester side: drives requests, observes grants.
  modport master (
    output HBUSREQ, HLOCK, HREADY, Valid,
    input  HGRANT, HMASTER, HMASTLOCK, beat_cnt
  );

  // Arbiter side.
  modport slave (
    input  HBUSREQ, HLOCK, HREADY, Valid,
    output HGRANT, HMASTER, HMASTLOCK, beat_cnt
  );

endinterface
`default_nettype wire

// File: rtl/ahb_apb_bus_arbiter_rr_select.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : rr_select                                                        |
// | Combinational round-robin picker: first requester after i_rr_ptr, wrapping.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module rr_select
  import ahb_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int MW          = mw_f(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] i_req,
  input  logic [MW-1:0]          i_rr_ptr,
  output logic [MW-1:0]          o_winner,
  output logic                   o_any_req
);

  logic [MW-1:0] w_idx;

  // Scan from the far end back toward rr_ptr+1 so the nearest requester wins last.
  always_comb begin
    o_winner = i_rr_ptr;
    w_idx    = i_rr_ptr;
    for (int i = NUM_MASTERS; i >= 1; i--) begin
      w_idx = MW'((int'(i_rr_ptr) + i) % NUM_MASTERS);
      if (i_req[w_idx]) begin
        o_winner = w_idx;
      end
    end
    o_any_req = |i_req;
  end

endmodule
`default_nettype wire

// File: rtl/ahb_apb_bus_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : ahb_apb_bus_arbiter                                              |
// | Round-robin AHB arbiter with lock support and beat-limit pre-emption.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module ahb_apb_bus_arbiter
  import ahb_arb_pkg::*;
#(
  parameter int NUM_MASTERS    = 4,
  parameter int MAX_BEATS      = 8,
  parameter int DEFAULT_MASTER = 0
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  ahb_apb_bus_arbiter_if.slave  bus
);

  localparam int MW = mw_f(NUM_MASTERS);
  localparam int BW = bw_f(MAX_BEATS);

  localparam logic [BW-1:0]          c_max_beats     = BW'(MAX_BEATS);
  localparam logic [MW-1:0]          c_default       = MW'(DEFAULT_MASTER);
  localparam logic [NUM_MASTERS-1:0] c_one           = NUM_MASTERS'(1);
  localparam logic [NUM_MASTERS-1:0] c_default_grant = c_one << DEFAULT_MASTER;

  arb_state_t             r_state, w_state_nxt;
  logic [NUM_MASTERS-1:0] r_hgrant, w_hgrant_nxt;
  logic [MW-1:0]          r_hmaster, w_hmaster_nxt;
  logic [MW-1:0]          r_rr_ptr, w_rr_ptr_nxt;
  logic                   r_hmastlock, w_hmastlock_nxt;
  logic [BW-1:0]          r_beat_cnt, w_beat_cnt_nxt;
  logic [BW-1:0]          w_cnt_inc;
  logic [MW-1:0]          w_winner;
  logic                   w_any_req, w_limit, w_others, w_rearb;

  rr_select #(
    .NUM_MASTERS (NUM_MASTERS),
    .MW          (MW)
  ) u_rr_select (
    .i_req     (bus.HBUSREQ),
    .i_rr_ptr  (r_rr_ptr),
    .o_winner  (w_winner),
    .o_any_req (w_any_req)
  );

  // Saturating beat count as it would stand after this edge.
  assign w_cnt_inc = (bus.Valid && bus.HREADY && (r_beat_cnt != c_max_beats))
                   ? r_beat_cnt + 1'b1 : r_beat_cnt;
  assign w_limit   = (w_cnt_inc == c_max_beats);
  assign w_others  = |(bus.HBUSREQ & ~r_hgrant);

  always_comb begin
    w_state_nxt     = r_state;
    w_hgrant_nxt    = r_hgrant;
    w_hmaster_nxt   = r_hmaster;
    w_rr_ptr_nxt    = r_rr_ptr;
    w_hmastlock_nxt = r_hmastlock;
    w_beat_cnt_nxt  = r_beat_cnt;
    w_rearb         = 1'b0;

    if (bus.HREADY) begin
      unique case (r_state)
        ST_PARK: begin
          w_beat_cnt_nxt = '0;
          w_rearb        = w_any_req;
        end
        ST_OWN, ST_LOCKED: begin
          // A held lock overrides both release and the beat limit.
          if (bus.HLOCK[r_hmaster]) begin
            w_state_nxt     = ST_LOCKED;
            w_hmastlock_nxt = 1'b1;
            w_beat_cnt_nxt  = w_cnt_inc;
          end else if (!bus.HBUSREQ[r_hmaster] || (w_limit && w_others)) begin
            w_rearb = 1'b1;
          end else begin
            w_state_nxt     = ST_OWN;
            w_hmastlock_nxt = 1'b0;
            w_beat_cnt_nxt  = w_limit ? '0 : w_cnt_inc;
          end
        end
        default: begin
          w_state_nxt = ST_PARK;
        end
      endcase

      if (w_rearb) begin
        w_beat_cnt_nxt = '0;
        if (w_any_req) begin
          w_hmaster_nxt   = w_winner;
          w_rr_ptr_nxt    = w_winner;
          w_hmastlock_nxt = bus.HLOCK[w_winner];
          w_state_nxt     = bus.HLOCK[w_winner] ? ST_LOCKED : ST_OWN;
        end else begin
          w_hmaster_nxt   = c_default;
          w_hmastlock_nxt = 1'b0;
          w_state_nxt     = ST_PARK;
        end
        w_hgrant_nxt = c_one << w_hmaster_nxt;
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state     <= ST_PARK;
      r_hgrant    <= c_default_grant;
      r_hmaster   <= c_default;
      r_rr_ptr    <= c_default;
      r_hmastlock <= 1'b0;
      r_beat_cnt  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_hgrant    <= w_hgrant_nxt;
      r_hmaster   <= w_hmaster_nxt;
      r_rr_ptr    <= w_rr_ptr_nxt;
      r_hmastlock <= w_hmastlock_nxt;
      r_beat_cnt  <= w_beat_cnt_nxt;
    end
  end

  assign bus.HGRANT    = r_hgrant;
  assign bus.HMASTER   = r_hmaster;
  assign bus.HMASTLOCK = r_hmastlock;
  assign bus.beat_cnt  = r_beat_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ahb_apb_bus_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_ahb_apb_bus_arbiter                                           |
// | Directed scenarios plus randomized traffic against a behavioural model.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_ahb_apb_bus_arbiter;

  localparam int N    = 4;
  localparam int MAXB = 8;

  logic HCLK;
  logic HRESETn;

  int errors = 0;
  int checks = 0;

  // Reference model: who owns the bus and how it got there.
  int m_owner, m_rr, m_cnt;
  bit m_lock, m_parked;

  ahb_apb_bus_arbiter_if #(.NUM_MASTERS(N), .MAX_BEATS(MAXB)) bus ();

  ahb_apb_bus_arbiter #(
    .NUM_MASTERS    (N),
    .MAX_BEATS      (MAXB),
    .DEFAULT_MASTER (0)
  ) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .bus     (bus)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  // Structural invariant: grant is one-hot and matches HMASTER.
  always @(negedge HCLK) begin
    if (HRESETn) begin
      checks++;
      if (!$onehot(bus.HGRANT) || (bus.HGRANT !== (4'b0001 << bus.HMASTER))) begin
        errors++;
        $display("FAIL onehot: HGRANT=%b HMASTER=%0d required one-hot matching index",
                 bus.HGRANT, bus.HMASTER);
      end
    end
  end

  task automatic model_reset();
    m_owner = 0; m_rr = 0; m_cnt = 0; m_lock = 0; m_parked = 1;
  endtask

  task automatic model_handover();
    int pick;
    logic [3:0] rq;
    rq   = bus.HBUSREQ;
    pick = -1;
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (m_rr + k) % N;
      if (pick < 0 && rq[idx[1:0]]) pick = idx;
    end
    m_cnt = 0;
    if (pick < 0) begin
      m_owner = 0; m_lock = 0; m_parked = 1;
    end else begin
      logic [3:0] lk;
      lk = bus.HLOCK;
      m_owner = pick; m_rr = pick; m_parked = 0; m_lock = lk[pick[1:0]];
    end
  endtask

  task automatic model_edge();
    int nxt;
    logic [3:0] rq, lk;
    rq = bus.HBUSREQ;
    lk = bus.HLOCK;
    if (!bus.HREADY) return;
    if (m_parked) begin
      m_cnt = 0;
      if (rq != 4'b0000) model_handover();
    end else begin
      nxt = (bus.Valid && m_cnt < MAXB) ? m_cnt + 1 : m_cnt;
      if (lk[m_owner[1:0]]) begin
        m_lock = 1; m_cnt = nxt;
      end else if (!rq[m_owner[1:0]] ||
                   (nxt == MAXB && (rq & ~(4'b0001 << m_owner)) != 4'b0000)) begin
        model_handover();
      end else begin
        m_lock = 0; m_cnt = (nxt == MAXB) ? 0 : nxt;
      end
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    if (HRESETn) model_edge();
    #1;
  endtask

  task automatic do_reset();
    bus.HBUSREQ = '0; bus.HLOCK = '0; bus.HREADY = 1'b1; bus.Valid = 1'b0;
    HRESETn = 1'b0;
    model_reset();
    @(posedge HCLK); #1;
    HRESETn = 1'b1;
  endtask

  task automatic test_reset();
    HRESETn = 1'b1;
    bus.HBUSREQ = '0; bus.HLOCK = '0; bus.HREADY = 1'b1; bus.Valid = 1'b0;
    #3 HRESETn = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({bus.HGRANT, bus.HMASTER, bus.HMASTLOCK, bus.beat_cnt} !== {4'b0001, 2'd0, 1'b0, 4'd0}) begin
      errors++;
      $display("FAIL reset_values: got grant=%b master=%0d lock=%b cnt=%0d required 0001/0/0/0",
               bus.HGRANT, bus.HMASTER, bus.HMASTLOCK, bus.beat_cnt);
    end
    @(posedge HCLK); #1;
    HRESETn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (bus.HGRANT !== 4'b0001 || bus.HMASTER !== 2'd0 || bus.HMASTLOCK !== 1'b0) begin
        errors++;
        $display("FAIL park_idle: cycle %0d got grant=%b master=%0d required 0001/0", i,
                 bus.HGRANT, bus.HMASTER);
      end
    end
  endtask

  task automatic test_grant_latency();
    do_reset();
    bus.HBUSREQ = 4'b0100;
    tick();
    checks++;
    if (bus.HGRANT !== 4'b0100 || bus.HMASTER !== 2'd2) begin
      errors++;
      $display("FAIL grant_latency: got grant=%b master=%0d required 0100/2", bus.HGRANT, bus.HMASTER);
    end
    bus.HBUSREQ = 4'b0000;
    tick();
    bus.HBUSREQ = 4'b1000;
    bus.HREADY  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus.HGRANT !== 4'b0001) begin
        errors++;
        $display("FAIL hready_hold: got grant=%b required 0001", bus.HGRANT);
      end
    end
    bus.HREADY = 1'b1;
    tick();
    checks++;
    if (bus.HGRANT !== 4'b1000 || bus.HMASTER !== 2'd3) begin
      errors++;
      $display("FAIL hready_release: got grant=%b master=%0d required 1000/3", bus.HGRANT, bus.HMASTER);
    end
  endtask

  task automatic test_rotation();
    do_reset();
    bus.HBUSREQ = 4'b1111; bus.Valid = 1'b1;
    tick();
    for (int t = 0; t < 5; t++) begin
      for (int b = 0; b < MAXB; b++) begin
        checks++;
        if (int'(bus.HMASTER) !== (1 + t) % N || int'(bus.beat_cnt) !== b) begin
          errors++;
          $display("FAIL rotation: turn %0d beat %0d got master=%0d cnt=%0d required %0d/%0d",
                   t, b, bus.HMASTER, bus.beat_cnt, (1 + t) % N, b);
        end
        tick();
      end
    end
  endtask

  task automatic test_lock();
    do_reset();
    bus.HBUSREQ = 4'b0010;
    tick();
    bus.HBUSREQ = 4'b1011; bus.HLOCK = 4'b0010; bus.Valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (bus.HMASTER !== 2'd1 || bus.HMASTLOCK !== 1'b1) begin
        errors++;
        $display("FAIL lock_hold: beat %0d got master=%0d lock=%b required 1/1", i, bus.HMASTER, bus.HMASTLOCK);
      end
    end
    checks++;
    if (int'(bus.beat_cnt) !== MAXB) begin
      errors++;
      $display("FAIL lock_saturate: got cnt=%0d required %0d", bus.beat_cnt, MAXB);
    end
    bus.HLOCK = 4'b0000;
    tick();
    checks++;
    if (bus.HMASTER !== 2'd3 || bus.HMASTLOCK !== 1'b0 || bus.beat_cnt !== 4'd0) begin
      errors++;
      $display("FAIL lock_release: got master=%0d lock=%b cnt=%0d required 3/0/0",
               bus.HMASTER, bus.HMASTLOCK, bus.beat_cnt);
    end
  endtask

  task automatic test_sole_owner();
    do_reset();
    bus.HBUSREQ = 4'b0100; bus.Valid = 1'b1;
    tick();
    for (int k = 1; k <= 30; k++) begin
      tick();
      checks++;
      if (bus.HGRANT !== 4'b0100 || int'(bus.beat_cnt) !== k % MAXB) begin
        errors++;
        $display("FAIL sole_owner: beat %0d got grant=%b cnt=%0d required 0100/%0d",
                 k, bus.HGRANT, bus.beat_cnt, k % MAXB);
      end
    end
    bus.HBUSREQ = 4'b0000;
    tick();
    checks++;
    if (bus.HGRANT !== 4'b0001 || bus.HMASTER !== 2'd0) begin
      errors++;
      $display("FAIL sole_park: got grant=%b master=%0d required 0001/0", bus.HGRANT, bus.HMASTER);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    bus.HBUSREQ = 4'b1000; bus.Valid = 1'b1;
    tick();
    bus.HLOCK = 4'b1000;
    tick(); tick(); tick();
    checks++;
    if (bus.HMASTER !== 2'd3 || bus.HMASTLOCK !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_lock: got master=%0d lock=%b required 3/1", bus.HMASTER, bus.HMASTLOCK);
    end
    #2 HRESETn = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({bus.HGRANT, bus.HMASTER, bus.HMASTLOCK, bus.beat_cnt} !== {4'b0001, 2'd0, 1'b0, 4'd0}) begin
      errors++;
      $display("FAIL async_reset: got grant=%b master=%0d lock=%b cnt=%0d required 0001/0/0/0",
               bus.HGRANT, bus.HMASTER, bus.HMASTLOCK, bus.beat_cnt);
    end
    bus.HLOCK = 4'b0000; bus.HBUSREQ = 4'b1001;
    @(posedge HCLK); #1;
    HRESETn = 1'b1;
    tick();
    checks++;
    if (bus.HMASTER !== 2'd3) begin
      errors++;
      $display("FAIL rr_restart: got master=%0d required 3", bus.HMASTER);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 5) == 0) bus.HBUSREQ = 4'($urandom);
      if ($urandom_range(0, 9) == 0) bus.HLOCK = 4'($urandom) & 4'($urandom) & bus.HBUSREQ;
      bus.HREADY = ($urandom_range(0, 3) != 0);
      bus.Valid  = ($urandom_range(0, 4) != 0);
      tick();
      checks++;
      if (int'(bus.HMASTER) !== m_owner || bus.HMASTLOCK !== m_lock ||
          int'(bus.beat_cnt) !== m_cnt || bus.HGRANT !== (4'b0001 << m_owner)) begin
        errors++;
        $display("FAIL random: cycle %0d got master=%0d lock=%b cnt=%0d required %0d/%0d/%0d",
                 i, bus.HMASTER, bus.HMASTLOCK, bus.beat_cnt, m_owner, m_lock, m_cnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_grant_latency();
    test_rotation();
    test_lock();
    test_sole_owner();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
